// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative RV32M divide/remainder unit:
// operation codes, FSM state encodings and default widths.
package div_unit_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'd0,
        DIV_OP_DIVU = 2'd1,
        DIV_OP_REM  = 2'd2,
        DIV_OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    function automatic logic is_signed_op(input div_op_e op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic is_quotient_op(input div_op_e op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_DIVU);
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring radix-2 division iteration: shift in the next dividend bit,
// then subtract the divisor when it fits.
module div_unit_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0] rem,
    input  logic          dvd_msb,
    input  logic [XLEN:0] div,
    output logic [XLEN:0] rem_next,
    output logic          q_bit
);

    logic [XLEN:0] shifted;

    always_comb begin
        shifted  = {rem[XLEN-1:0], dvd_msb};
        q_bit    = (shifted >= div);
        rem_next = q_bit ? (shifted - div) : shifted;
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divide/remainder unit with valid/ready request and response
// ports; one operation in flight, killable by flush.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            busy
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state, state_next;
    div_op_e         op_r;
    logic [XLEN:0]   rem_r, div_r;
    logic [XLEN-1:0] dvd_r;
    logic [CNT_W-1:0] cnt_r;
    logic            sign_quo, sign_rem;

    div_op_e         req_op;
    logic            req_signed, a_neg, b_neg, special, accept;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN:0]   step_rem;
    logic            step_q;

    // Request decode: operands become magnitudes for signed ops, and the two
    // corner cases that bypass the iteration are detected here.
    always_comb begin
        req_op     = div_op_e'(in_op);
        req_signed = is_signed_op(req_op);
        a_neg      = req_signed && in_a[XLEN-1];
        b_neg      = req_signed && in_b[XLEN-1];
        abs_a      = a_neg ? -in_a : in_a;
        abs_b      = b_neg ? -in_b : in_b;
        special    = (in_b == '0) ||
                     (req_signed && (in_a == MIN_INT) && (in_b == '1));
        accept     = (state == DIV_IDLE) && in_valid && !flush;
    end

    div_unit_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_r),
        .dvd_msb  (dvd_r[XLEN-1]),
        .div      (div_r),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: if (in_valid) state_next = special ? DIV_FIX : DIV_CALC;
                DIV_CALC: if (cnt_r == CNT_W'(1)) state_next = DIV_FIX;
                DIV_FIX:  state_next = DIV_DONE;
                DIV_DONE: if (out_valid && out_ready) state_next = DIV_IDLE;
                default:  state_next = DIV_IDLE;
            endcase
        end
    end

    // Quotient bits shift into the low end of the dividend register, so at the
    // end of CALC dvd_r holds the quotient magnitude and rem_r the remainder.
    // out_valid is registered, so it rises one cycle after entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r      <= DIV_OP_DIV;
            rem_r     <= '0;
            div_r     <= '0;
            dvd_r     <= '0;
            cnt_r     <= '0;
            sign_quo  <= 1'b0;
            sign_rem  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= (state == DIV_DONE) && (state_next == DIV_DONE);
            if (accept) begin
                op_r  <= req_op;
                div_r <= {1'b0, abs_b};
                cnt_r <= CNT_W'(XLEN);
                if (in_b == '0) begin
                    dvd_r    <= '1;
                    rem_r    <= {1'b0, in_a};
                    sign_quo <= 1'b0;
                    sign_rem <= 1'b0;
                end else if (special) begin
                    dvd_r    <= in_a;
                    rem_r    <= '0;
                    sign_quo <= 1'b0;
                    sign_rem <= 1'b0;
                end else begin
                    dvd_r    <= abs_a;
                    rem_r    <= '0;
                    sign_quo <= a_neg ^ b_neg;
                    sign_rem <= a_neg;
                end
            end else if (state == DIV_CALC) begin
                rem_r <= step_rem;
                dvd_r <= {dvd_r[XLEN-2:0], step_q};
                cnt_r <= cnt_r - CNT_W'(1);
            end else if ((state == DIV_FIX) && !flush) begin
                if (is_quotient_op(op_r))
                    out_data <= sign_quo ? -dvd_r : dvd_r;
                else
                    out_data <= sign_rem ? -rem_r[XLEN-1:0] : rem_r[XLEN-1:0];
            end
        end
    end

    assign in_ready = (state == DIV_IDLE);
    assign busy     = (state != DIV_IDLE);

endmodule
